modulo_emisor_hamming: RTL and testbench

- Transmit side of the team's Hamming SECDED link.
- Samples 4 data switches when the send button is pressed and encodes them into an 8-bit extended Hamming(7,4) word (7 Hamming bits plus overall even parity).
- Can inject 0, 1 or 2 bit errors for demonstration.
- Presents the word on a valid/ready handshake to the channel that feeds the decoder/corrector chain.

---
 rtl/modulo_emisor_hamming.sv | 158 +++++++++++++++
 tb/tb_modulo_emisor_hamming.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/modulo_emisor_hamming.sv
// Hamming SECDED link transmitter: samples 4 data switches on a send press,
// encodes them into an 8-bit extended Hamming(7,4) word and offers it on valid/ready.
module modulo_emisor_hamming #(
  parameter int ETAPAS_SYNC = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] sw_datos,
  input  logic       boton_enviar,
  input  logic [1:0] err_modo,
  input  logic [2:0] err_pos_a,
  input  logic [2:0] err_pos_b,
  input  logic       listo,
  output logic [7:0] palabra_tx,
  output logic       palabra_valida,
  output logic       ocupado,
  output logic [7:0] contador_tramas
);

  typedef enum logic [1:0] {
    IDLE,
    CAPTURA,
    CODIFICA,
    ENVIO
  } estado_t;

  estado_t estado_q, estado_d;

  logic [ETAPAS_SYNC-1:0]      btn_sync_q;
  logic [ETAPAS_SYNC-1:0][3:0] sw_sync_q;
  logic                        btn_prev_q;
  logic                        btn_s;
  logic [3:0]                  sw_s;
  logic                        envio;

  logic [3:0] datos_q, datos_d;
  logic [1:0] modo_q, modo_d;
  logic [2:0] pos_a_q, pos_a_d;
  logic [2:0] pos_b_q, pos_b_d;
  logic [7:0] tx_q, tx_d;
  logic       valida_q, valida_d;
  logic [7:0] cnt_q, cnt_d;

  logic [6:0] h;
  logic [7:0] mascara;
  logic [7:0] palabra_cod;

  assign btn_s = btn_sync_q[ETAPAS_SYNC-1];
  assign sw_s  = sw_sync_q[ETAPAS_SYNC-1];
  // Rising edge only, so a held button sends once.
  assign envio = btn_s & ~btn_prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      btn_sync_q <= '0;
      sw_sync_q  <= '0;
      btn_prev_q <= 1'b0;
    end else begin
      btn_sync_q <= {btn_sync_q[ETAPAS_SYNC-2:0], boton_enviar};
      sw_sync_q  <= {sw_sync_q[ETAPAS_SYNC-2:0], sw_datos};
      btn_prev_q <= btn_s;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      estado_q <= IDLE;
    end else begin
      estado_q <= estado_d;
    end
  end

  always_comb begin
    estado_d = estado_q;
    unique case (estado_q)
      IDLE:     if (envio) estado_d = CAPTURA;
      CAPTURA:  estado_d = CODIFICA;
      CODIFICA: estado_d = ENVIO;
      ENVIO:    if (valida_q && listo) estado_d = IDLE;
    endcase
  end

  always_comb begin
    h[0] = datos_q[0] ^ datos_q[1] ^ datos_q[3];
    h[1] = datos_q[0] ^ datos_q[2] ^ datos_q[3];
    h[2] = datos_q[0];
    h[3] = datos_q[1] ^ datos_q[2] ^ datos_q[3];
    h[4] = datos_q[1];
    h[5] = datos_q[2];
    h[6] = datos_q[3];
    // Equal positions in mode 2 collapse to a single flip.
    mascara = '0;
    case (modo_q)
      2'd1: mascara[pos_a_q] = 1'b1;
      2'd2: begin
        mascara[pos_a_q] = 1'b1;
        mascara[pos_b_q] = 1'b1;
      end
      default: mascara = '0;
    endcase
    palabra_cod = {^h, h} ^ mascara;
  end

  always_comb begin
    datos_d  = datos_q;
    modo_d   = modo_q;
    pos_a_d  = pos_a_q;
    pos_b_d  = pos_b_q;
    tx_d     = tx_q;
    valida_d = valida_q;
    cnt_d    = cnt_q;
    unique case (estado_q)
      IDLE: ;
      CAPTURA: begin
        datos_d = sw_s;
        modo_d  = err_modo;
        pos_a_d = err_pos_a;
        pos_b_d = err_pos_b;
      end
      CODIFICA: begin
        tx_d     = palabra_cod;
        valida_d = 1'b1;
      end
      ENVIO: begin
        if (valida_q && listo) begin
          valida_d = 1'b0;
          cnt_d    = cnt_q + 8'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      datos_q  <= '0;
      modo_q   <= '0;
      pos_a_q  <= '0;
      pos_b_q  <= '0;
      tx_q     <= '0;
      valida_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      datos_q  <= datos_d;
      modo_q   <= modo_d;
      pos_a_q  <= pos_a_d;
      pos_b_q  <= pos_b_d;
      tx_q     <= tx_d;
      valida_q <= valida_d;
      cnt_q    <= cnt_d;
    end
  end

  assign ocupado         = (estado_q != IDLE);
  assign palabra_tx      = tx_q;
  assign palabra_valida  = valida_q;
  assign contador_tramas = cnt_q;

endmodule

// File: tb/tb_modulo_emisor_hamming.sv
// Directed bench for modulo_emisor_hamming: encoding table, error injection,
// handshake stalls, reset in flight and transfer counter wrap.
module tb_modulo_emisor_hamming;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] sw;
  logic       boton;
  logic [1:0] modo;
  logic [2:0] pa;
  logic [2:0] pb;
  logic       listo;
  logic [7:0] tx;
  logic       valida;
  logic       ocupado;
  logic [7:0] cnt;

  always #5 clk = ~clk;

  modulo_emisor_hamming #(.ETAPAS_SYNC(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .sw_datos       (sw),
    .boton_enviar   (boton),
    .err_modo       (modo),
    .err_pos_a      (pa),
    .err_pos_b      (pb),
    .listo          (listo),
    .palabra_tx     (tx),
    .palabra_valida (valida),
    .ocupado        (ocupado),
    .contador_tramas(cnt)
  );

  typedef struct {
    logic [3:0] d;
    logic [1:0] m;
    logic [2:0] a;
    logic [2:0] b;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[10];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   exp_cnt;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Press for one cycle; lat = edges from first sampled edge to valid (incl.)
  task automatic press_wait(output logic [7:0] w, output int lat,
                            output logic busy);
    lat  = 0;
    w    = '0;
    busy = 1'b0;
    repeat (3) @(negedge clk);
    boton = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk);
      #1;
      if (k == 1) boton = 1'b0;
      if (valida) begin
        lat  = k;
        w    = tx;
        busy = ocupado;
        break;
      end
    end
  endtask

  logic [7:0] w;
  int         lat;
  logic       busy;
  logic       extra;

  initial begin
    vecs[0] = '{4'b1011, 2'd0, 3'd0, 3'd0, 8'h55};
    vecs[1] = '{4'b0000, 2'd0, 3'd0, 3'd0, 8'h00};
    vecs[2] = '{4'b1111, 2'd0, 3'd0, 3'd0, 8'hFF};
    vecs[3] = '{4'b0001, 2'd0, 3'd0, 3'd0, 8'h87};
    vecs[4] = '{4'b1011, 2'd1, 3'd4, 3'd0, 8'h45};
    vecs[5] = '{4'b0000, 2'd2, 3'd0, 3'd7, 8'h81};
    vecs[6] = '{4'b0000, 2'd2, 3'd3, 3'd3, 8'h08};
    vecs[7] = '{4'b1011, 2'd3, 3'd1, 3'd2, 8'h55};
    vecs[8] = '{4'b0001, 2'd1, 3'd7, 3'd0, 8'h07};
    vecs[9] = '{4'b0000, 2'd1, 3'd0, 3'd5, 8'h01};

    rst   = 1'b1;
    sw    = '0;
    boton = 1'b0;
    modo  = '0;
    pa    = '0;
    pb    = '0;
    listo = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx", tx, 8'h00);
    check("rst_valid", valida, 1'b0);
    check("rst_busy", ocupado, 1'b0);
    check("rst_cnt", cnt, 8'h00);
    rst = 1'b0;
    exp_cnt = 0;

    for (int i = 0; i < 10; i++) begin
      sw   = vecs[i].d;
      modo = vecs[i].m;
      pa   = vecs[i].a;
      pb   = vecs[i].b;
      press_wait(w, lat, busy);
      check($sformatf("lat_%0d", i), lat, 5);
      check($sformatf("word_%0d", i), w, vecs[i].exp);
      check($sformatf("busy_%0d", i), busy, 1'b1);
      @(posedge clk);
      #1;
      exp_cnt++;
      check($sformatf("vdrop_%0d", i), valida, 1'b0);
      check($sformatf("cnt_%0d", i), cnt, exp_cnt);
      check($sformatf("idle_%0d", i), ocupado, 1'b0);
    end

    // Stalled handshake with input churn and a re-press
    sw    = 4'b0001;
    modo  = 2'd0;
    listo = 1'b0;
    press_wait(w, lat, busy);
    check("hs_lat", lat, 5);
    check("hs_word", w, 8'h87);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      sw = sw + 4'd5;
      if (i == 3) boton = 1'b1;
      check($sformatf("hs_tx_%0d", i), tx, 8'h87);
      check($sformatf("hs_v_%0d", i), valida, 1'b1);
    end
    listo = 1'b1;
    @(posedge clk);
    #1;
    exp_cnt++;
    check("hs_vdrop", valida, 1'b0);
    check("hs_cnt", cnt, exp_cnt);
    check("hs_idle", ocupado, 1'b0);
    extra = 1'b0;
    repeat (10) begin
      @(posedge clk);
      #1;
      extra = extra | ocupado | valida;
    end
    check("held_no_send", extra, 1'b0);
    check("held_cnt", cnt, exp_cnt);
    boton = 1'b0;

    // Reset while a word waits in ENVIO
    sw    = 4'b1111;
    listo = 1'b0;
    press_wait(w, lat, busy);
    check("rv_lat", lat, 5);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_cnt = 0;
    check("rv_valid", valida, 1'b0);
    check("rv_busy", ocupado, 1'b0);
    check("rv_cnt", cnt, exp_cnt);
    check("rv_tx", tx, 8'h00);
    listo = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("rv_dropped", cnt, exp_cnt);

    // Counter wrap
    sw = 4'b0110;
    for (int i = 0; i < 256; i++) begin
      press_wait(w, lat, busy);
      if (lat != 5) check("wrap_lat", lat, 5);
      @(posedge clk);
      #1;
      exp_cnt = (exp_cnt + 1) % 256;
      if (i == 254) check("wrap_255", cnt, 8'd255);
    end
    check("wrap_0", cnt, exp_cnt);
    check("wrap_word", w, 8'h33);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
